aesl_deadlock_detector: RTL and testbench

Cosim deadlock detector consuming the registered `block` flags of the per-process deadlock monitors (one bit per monitored dataflow process). It declares a deadlock when at least one monitor reports blocking for `TIMEOUT` consecutive cycles with no dataflow progress. It then presents a one-shot report over a valid/ready handshake and holds a sticky `deadlock` flag until reset. It sits directly downstream of the monitor instances in the AESL testbench and upstream of the testbench's reporting/abort logic.

---
 rtl/aesl_deadlock_detector_if.sv | 24 ++
 rtl/aesl_deadlock_detector.sv | 86 ++++++++
 tb/tb_aesl_deadlock_detector.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aesl_deadlock_detector_if.sv
// aesl_deadlock_detector_if: monitor inputs and deadlock report handshake for aesl_deadlock_detector.
interface aesl_deadlock_detector_if #(
  parameter int N_MON = 4,
  parameter int IDX_W = (N_MON > 1) ? $clog2(N_MON) : 1,
  parameter int CNT_W = 32
);
  logic [N_MON-1:0] mon_block;
  logic             progress;
  logic             dl_valid;
  logic             dl_ready;
  logic [N_MON-1:0] dl_mask;
  logic [IDX_W-1:0] dl_first_idx;
  logic [CNT_W-1:0] dl_cycles;
  logic             deadlock;
  logic             watching;
  modport master (
    output mon_block, progress, dl_ready,
    input  dl_valid, dl_mask, dl_first_idx, dl_cycles, deadlock, watching
  );
  modport slave (
    input  mon_block, progress, dl_ready,
    output dl_valid, dl_mask, dl_first_idx, dl_cycles, deadlock, watching
  );
endinterface

// File: rtl/aesl_deadlock_detector.sv
// aesl_deadlock_detector: flags TIMEOUT consecutive blocked, no-progress cycles and reports once.
// Define AESL_DEADLOCK_TIMESTAMP_EN to build the cycle counter behind dl_cycles.
module aesl_deadlock_detector #(
  parameter int N_MON   = 4,
  parameter int TIMEOUT = 1000,
  parameter int IDX_W   = (N_MON > 1) ? $clog2(N_MON) : 1,
  parameter int CNT_W   = 32
) (
  input logic clock,
  input logic reset,
  aesl_deadlock_detector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WATCH, REPORT, HALTED} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_MON-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d, low_idx;
  logic             blk, hit;
  assign blk = |bus.mon_block & ~bus.progress;
  always_comb begin
    low_idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) low_idx = bus.mon_block[i] ? IDX_W'(i) : low_idx;
  end
  // the counter saturates at TIMEOUT-1; the transition to REPORT replaces the final increment
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    hit     = 1'b0;
    case (state_q)
      IDLE: if (blk) begin
        hit     = (TIMEOUT == 1);
        state_d = hit ? REPORT : WATCH;
        cnt_d   = hit ? '0 : CNT_W'(1);
        mask_d  = bus.mon_block;
        idx_d   = low_idx;
      end
      WATCH: if (blk) begin
        hit     = (cnt_q == LAST);
        state_d = hit ? REPORT : WATCH;
        cnt_d   = hit ? cnt_q : cnt_q + CNT_W'(1);
        mask_d  = mask_q | bus.mon_block;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
      end
      REPORT: state_d = bus.dl_ready ? HALTED : REPORT;
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
    end
  end
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, stamp_q, stamp_d;
  always_comb begin
    cyc_d   = cyc_q + CNT_W'(1);
    stamp_d = hit ? cyc_q : stamp_q;
  end
  always_ff @(posedge clock) begin
    cyc_q   <= reset ? '0 : cyc_d;
    stamp_q <= reset ? '0 : stamp_d;
  end
  assign bus.dl_cycles = stamp_q;
`else
  assign bus.dl_cycles = '0;
`endif
  assign bus.dl_valid     = (state_q == REPORT);
  assign bus.deadlock     = (state_q == HALTED);
  assign bus.watching     = (cnt_q != '0);
  assign bus.dl_mask      = mask_q;
  assign bus.dl_first_idx = idx_q;
endmodule

// File: tb/tb_aesl_deadlock_detector.sv
// tb_aesl_deadlock_detector: directed plus random stimulus on TIMEOUT=8 and TIMEOUT=1 instances against a run-length model.
module tb_aesl_deadlock_detector;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  aesl_deadlock_detector_if #(.N_MON(4), .IDX_W(2), .CNT_W(32)) b0 ();
  aesl_deadlock_detector_if #(.N_MON(4), .IDX_W(2), .CNT_W(32)) b1 ();
  aesl_deadlock_detector #(.N_MON(4), .TIMEOUT(8), .IDX_W(2), .CNT_W(32)) dut0 (.clock(clock), .reset(reset), .bus(b0));
  aesl_deadlock_detector #(.N_MON(4), .TIMEOUT(1), .IDX_W(2), .CNT_W(32)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  int total = 0;
  int fails = 0;
  int tmo [2] = '{8, 1};
  int run [2];
  bit rep [2];
  bit halt [2];
  logic [3:0]  m_mask [2];
  logic [1:0]  m_first [2];
  logic [31:0] m_cyc [2];
  logic [31:0] m_stamp [2];
  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) lowest = 2'(i);
  endfunction
  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask
  // model: a report fires once the current run of consecutive blocked cycles reaches TIMEOUT
  task automatic model(input int d, input logic [3:0] mb, input logic pg, input logic rd, input logic rs);
    if (rs) begin
      run[d] = 0; rep[d] = 0; halt[d] = 0;
      m_mask[d] = 0; m_first[d] = 0; m_cyc[d] = 0; m_stamp[d] = 0;
    end else begin
      if (halt[d]) begin
      end else if (rep[d]) begin
        if (rd) halt[d] = 1;
      end else if (mb != 0 && !pg) begin
        if (run[d] == 0) begin
          m_first[d] = lowest(mb);
          m_mask[d] = mb;
        end else m_mask[d] = m_mask[d] | mb;
        run[d]++;
        if (run[d] == tmo[d]) begin
          rep[d] = 1;
          m_stamp[d] = m_cyc[d];
        end
      end else begin
        run[d] = 0;
        m_mask[d] = 0;
      end
      m_cyc[d] = m_cyc[d] + 1;
    end
  endtask
  task automatic cmp(input int d, input logic v, input logic dl, input logic w,
                     input logic [3:0] m, input logic [1:0] f, input logic [31:0] c);
    logic [31:0] exp_c;
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    exp_c = m_stamp[d];
`else
    exp_c = 32'd0;
`endif
    chk("dl_valid", d, 32'(v), 32'(rep[d] && !halt[d]));
    chk("deadlock", d, 32'(dl), 32'(halt[d]));
    chk("dl_mask", d, 32'(m), 32'(m_mask[d]));
    chk("dl_first_idx", d, 32'(f), 32'(m_first[d]));
    chk("dl_cycles", d, c, exp_c);
    if (!rep[d]) chk("watching", d, 32'(w), 32'(run[d] > 0));
  endtask
  task automatic step(input logic [3:0] mb, input logic pg, input logic rd, input logic rs);
    b0.mon_block = mb; b1.mon_block = mb;
    b0.progress = pg;  b1.progress = pg;
    b0.dl_ready = rd;  b1.dl_ready = rd;
    reset = rs;
    @(posedge clock);
    model(0, mb, pg, rd, rs);
    model(1, mb, pg, rd, rs);
    @(negedge clock);
    cmp(0, b0.dl_valid, b0.deadlock, b0.watching, b0.dl_mask, b0.dl_first_idx, b0.dl_cycles);
    cmp(1, b1.dl_valid, b1.deadlock, b1.watching, b1.dl_mask, b1.dl_first_idx, b1.dl_cycles);
  endtask
  initial begin
    logic [31:0] c7, c15;
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    c7 = 32'd7; c15 = 32'd15;
`else
    c7 = 32'd0; c15 = 32'd0;
`endif
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 0, 32'(b0.dl_valid), 32'd0);
    chk("rst_watching", 0, 32'(b0.watching), 32'd0);
    repeat (7) step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("s1_early", 0, 32'(b0.dl_valid), 32'd0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("s1_valid", 0, 32'(b0.dl_valid), 32'd1);
    chk("s1_mask", 0, 32'(b0.dl_mask), 32'h4);
    chk("s1_first", 0, 32'(b0.dl_first_idx), 32'd2);
    chk("s1_cycles", 0, b0.dl_cycles, c7);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (7) step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("s2_watch", 0, 32'(b0.watching), 32'd1);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    chk("s2_break", 0, 32'(b0.watching), 32'd0);
    repeat (7) step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("s2_early", 0, 32'(b0.dl_valid), 32'd0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("s2_valid", 0, 32'(b0.dl_valid), 32'd1);
    chk("s2_cycles", 0, b0.dl_cycles, c15);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (4) step(4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (4) step(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("s3_valid", 0, 32'(b0.dl_valid), 32'd1);
    chk("s3_mask", 0, 32'(b0.dl_mask), 32'h9);
    chk("s3_first", 0, 32'(b0.dl_first_idx), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0, 1'b0);
      chk("s4_hold", 0, 32'(b0.dl_valid), 32'd1);
    end
    step(4'b1000, 1'b0, 1'b1, 1'b0);
    chk("s4_accept_valid", 0, 32'(b0.dl_valid), 32'd0);
    chk("s4_accept_dl", 0, 32'(b0.deadlock), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(4'(i[0] ? 4'b0101 : 4'b1010), 1'b0, 1'($urandom_range(1)), 1'b0);
      chk("s4_sticky", 0, 32'(b0.deadlock), 32'd1);
    end
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (8) step(4'b0110, 1'b0, 1'b0, 1'b0);
    chk("s5_valid", 0, 32'(b0.dl_valid), 32'd1);
    step(4'b0110, 1'b0, 1'b1, 1'b1);
    chk("s5_rst_valid", 0, 32'(b0.dl_valid), 32'd0);
    chk("s5_rst_dl", 0, 32'(b0.deadlock), 32'd0);
    chk("s5_rst_mask", 0, 32'(b0.dl_mask), 32'd0);
    repeat (7) step(4'b0110, 1'b0, 1'b0, 1'b0);
    chk("s5_early", 0, 32'(b0.dl_valid), 32'd0);
    step(4'b0110, 1'b0, 1'b0, 1'b0);
    chk("s5_valid2", 0, 32'(b0.dl_valid), 32'd1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 1, 32'(b1.dl_valid), 32'd1);
    chk("t1_first", 1, 32'(b1.dl_first_idx), 32'd1);
    repeat (80) begin
      if ($urandom_range(2) == 0) step(4'b0000, 1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(4, 30))
        step(($urandom_range(9) < 7) ? 4'($urandom_range(1, 15)) : 4'd0,
             1'($urandom_range(19) == 0), 1'($urandom_range(3) == 0), 1'($urandom_range(199) == 0));
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
